// File: rtl/ponk_pkg.sv
// Playfield geometry, ball/paddle constants and the sequencer state type
// shared by the ball sequencer and its deflection helper.
package ponk_pkg;

  localparam logic [9:0] FIELD_H   = 10'd480;
  localparam logic [9:0] BALL_SZ   = 10'd8;
  localparam logic [9:0] PADDLE_H  = 10'd64;
  localparam logic [9:0] PADDLE_W  = 10'd8;
  localparam logic [9:0] LPADDLE_X = 10'd16;
  localparam logic [9:0] RPADDLE_X = 10'd616;
  localparam logic [9:0] CX        = 10'd316;
  localparam logic [9:0] CY        = 10'd236;
  localparam logic [9:0] VX        = 10'd4;
  localparam logic [2:0] VY_MAX    = 3'd7;

  // Derived positions: paddle faces the ball is clamped to, right miss line, floor
  localparam logic [9:0] LFACE_X   = LPADDLE_X + PADDLE_W;
  localparam logic [9:0] RFACE_X   = RPADDLE_X - BALL_SZ;
  localparam logic [9:0] RMISS_X   = RPADDLE_X + PADDLE_W - VX;
  localparam logic [9:0] Y_BOTTOM  = FIELD_H - BALL_SZ;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_MOVE = 3'd2,
    S_WALL = 3'd3,
    S_PAD  = 3'd4
  } state_e;

  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/ball_sequencer_if.sv
// Control inputs and ball/score outputs of the ball sequencer.
interface ball_sequencer_if;

  logic       frame_tick;
  logic       serve;
  logic [9:0] lpaddle_y;
  logic [9:0] rpaddle_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] deflect;
  logic       goal_l;
  logic       goal_r;
  logic       busy;

  modport master (
    output frame_tick, serve, lpaddle_y, rpaddle_y,
    input  ball_x, ball_y, deflect, goal_l, goal_r, busy
  );

  modport slave (
    input  frame_tick, serve, lpaddle_y, rpaddle_y,
    output ball_x, ball_y, deflect, goal_l, goal_r, busy
  );

endinterface

// File: rtl/paddle_deflect.sv
// Offset of the ball centre from a paddle centre, returned as sign+magnitude
// together with the resulting vertical speed (up flag and clamped magnitude).
module paddle_deflect
  import ponk_pkg::*;
(
  input  logic [9:0] ball_y_i,
  input  logic [9:0] paddle_y_i,
  output logic [9:0] deflect_o,
  output logic       vy_up_o,
  output logic [2:0] vy_mag_o
);

  logic [9:0] offset_s;
  logic [8:0] mag_s;
  logic [8:0] mag_div_s;

  assign offset_s = (ball_y_i + (BALL_SZ >> 1)) - (paddle_y_i + (PADDLE_H >> 1));

  // Magnitude of the two's complement offset and its clamped speed
  always_comb begin
    mag_s = offset_s[8:0];
    if (offset_s[9]) begin
      mag_s = 9'd0 - offset_s[8:0];
    end else begin
      mag_s = offset_s[8:0];
    end
    mag_div_s = mag_s >> 2;
    if (mag_div_s > {6'd0, VY_MAX}) begin
      vy_mag_o = VY_MAX;
    end else begin
      vy_mag_o = mag_div_s[2:0];
    end
  end

  assign deflect_o = {offset_s[9], mag_s};
  assign vy_up_o   = offset_s[9];

endmodule

// File: rtl/ball_sequencer.sv
// Pong ball sequencer: per frame tick the ball is moved, bounced off the walls
// and tested against the paddle on its side of travel (MOVE -> WALL -> PAD).
module ball_sequencer
  import ponk_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  ball_sequencer_if.slave bus
);

  state_e      state_q, state_d;
  logic [9:0]  ball_x_q, ball_x_d;
  logic [10:0] ball_y_q, ball_y_d;   // bit 10 flags a borrow past the top wall
  logic [2:0]  vy_q, vy_d;
  logic        vy_up_q, vy_up_d;
  logic        right_q, right_d;
  logic        serve_right_q, serve_right_d;
  logic [9:0]  deflect_q, deflect_d;
  logic        goal_l_q, goal_l_d;
  logic        goal_r_q, goal_r_d;
  logic        busy_q, busy_d;

  logic [9:0]  pad_y_s;
  logic [9:0]  pd_deflect_s;
  logic        pd_up_s;
  logic [2:0]  pd_mag_s;
  logic        overlap_s;
  logic        side_s;
  logic        hit_s;

  assign pad_y_s = right_q ? bus.rpaddle_y : bus.lpaddle_y;

  paddle_deflect u_deflect (
    .ball_y_i   (ball_y_q[9:0]),
    .paddle_y_i (pad_y_s),
    .deflect_o  (pd_deflect_s),
    .vy_up_o    (pd_up_s),
    .vy_mag_o   (pd_mag_s)
  );

  assign overlap_s = ((ball_y_q + ext11(BALL_SZ)) > ext11(pad_y_s)) &&
                     (ball_y_q < (ext11(pad_y_s) + ext11(PADDLE_H)));
  assign side_s    = right_q ? ((ext11(ball_x_q) + ext11(BALL_SZ)) >= ext11(RPADDLE_X))
                             : (ball_x_q <= LFACE_X);
  assign hit_s     = overlap_s && side_s;

  // Next-state and datapath update for the frame sequence
  always_comb begin
    state_d       = state_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    vy_d          = vy_q;
    vy_up_d       = vy_up_q;
    right_d       = right_q;
    serve_right_d = serve_right_q;
    deflect_d     = deflect_q;
    goal_l_d      = 1'b0;
    goal_r_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ball_x_d = CX;
        ball_y_d = ext11(CY);
        vy_d     = 3'd0;
        vy_up_d  = 1'b0;
        if (bus.serve) begin
          state_d       = S_WAIT;
          right_d       = serve_right_q;
          serve_right_d = ~serve_right_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.frame_tick) begin
          state_d = S_MOVE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_MOVE: begin
        if ((!right_q && (ball_x_q < VX)) || (right_q && (ball_x_q > RMISS_X))) begin
          goal_r_d = ~right_q;
          goal_l_d = right_q;
          state_d  = S_IDLE;
          ball_x_d = CX;
          ball_y_d = ext11(CY);
          vy_d     = 3'd0;
          vy_up_d  = 1'b0;
        end else begin
          ball_x_d = right_q ? (ball_x_q + VX) : (ball_x_q - VX);
          ball_y_d = vy_up_q ? (ball_y_q - {8'd0, vy_q}) : (ball_y_q + {8'd0, vy_q});
          state_d  = S_WALL;
        end
      end
      S_WALL: begin
        if (vy_up_q && (ball_y_q[10] || (ball_y_q == 11'd0))) begin
          ball_y_d = 11'd0;
          vy_up_d  = 1'b0;
        end else if (!vy_up_q && (ball_y_q >= ext11(Y_BOTTOM))) begin
          ball_y_d = ext11(Y_BOTTOM);
          vy_up_d  = 1'b1;
        end else begin
          ball_y_d = ball_y_q;
        end
        state_d = S_PAD;
      end
      S_PAD: begin
        if (hit_s) begin
          deflect_d = pd_deflect_s;
          vy_up_d   = pd_up_s;
          vy_d      = pd_mag_s;
          right_d   = ~right_q;
          ball_x_d  = right_q ? RFACE_X : LFACE_X;
        end else begin
          deflect_d = deflect_q;
        end
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_MOVE) || (state_d == S_WALL) || (state_d == S_PAD);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ball_x_q      <= CX;
      ball_y_q      <= ext11(CY);
      vy_q          <= 3'd0;
      vy_up_q       <= 1'b0;
      right_q       <= 1'b0;
      serve_right_q <= 1'b0;
      deflect_q     <= 10'd0;
      goal_l_q      <= 1'b0;
      goal_r_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      vy_q          <= vy_d;
      vy_up_q       <= vy_up_d;
      right_q       <= right_d;
      serve_right_q <= serve_right_d;
      deflect_q     <= deflect_d;
      goal_l_q      <= goal_l_d;
      goal_r_q      <= goal_r_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.ball_x  = ball_x_q;
  assign bus.ball_y  = ball_y_q[9:0];
  assign bus.deflect = deflect_q;
  assign bus.goal_l  = goal_l_q;
  assign bus.goal_r  = goal_r_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_ball_sequencer.sv
// Scoreboard bench for ball_sequencer: a behavioural ball model predicts each
// frame's result, which is compared once busy falls.
module tb_ball_sequencer;

  logic clk = 1'b0;
  logic reset_n;

  ball_sequencer_if bif ();

  ball_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] deflect;
    logic [1:0] goals;     // {goal_l, goal_r}
    logic [3:0] busy_len;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // behavioural model of the ball; vy is signed (negative = up)
  int   m_x, m_y, m_vy, m_deflect;
  bit   m_right, m_serve_right;

  function automatic void model_centre();
    m_x  = 316;
    m_y  = 236;
    m_vy = 0;
  endfunction

  function automatic void model_reset();
    model_centre();
    m_deflect     = 0;
    m_right       = 1'b0;
    m_serve_right = 1'b0;
  endfunction

  function automatic void model_serve();
    m_right       = m_serve_right;
    m_serve_right = !m_serve_right;
  endfunction

  function automatic obs_t model_frame();
    obs_t e;
    int   py, off, mag;
    e.goals    = 2'b00;
    e.busy_len = 4'd3;
    if (!m_right && m_x < 4) begin
      e.goals    = 2'b01;
      e.busy_len = 4'd1;
      model_centre();
    end else if (m_right && m_x > 620) begin
      e.goals    = 2'b10;
      e.busy_len = 4'd1;
      model_centre();
    end else begin
      m_x = m_right ? m_x + 4 : m_x - 4;
      m_y = m_y + m_vy;
      if (m_vy < 0 && m_y <= 0) begin
        m_y  = 0;
        m_vy = -m_vy;
      end else if (m_vy > 0 && m_y >= 472) begin
        m_y  = 472;
        m_vy = -m_vy;
      end
      py = m_right ? int'(bif.rpaddle_y) : int'(bif.lpaddle_y);
      if (((m_right && m_x + 8 >= 616) || (!m_right && m_x <= 24)) &&
          (m_y + 8 > py) && (m_y < py + 64)) begin
        off       = (m_y + 4) - (py + 32);
        mag       = (off < 0) ? -off : off;
        m_deflect = (off < 0) ? 512 + mag : mag;
        m_vy      = (mag / 4 > 7) ? 7 : mag / 4;
        if (off < 0) m_vy = -m_vy;
        m_x       = m_right ? 608 : 24;
        m_right   = !m_right;
      end
    end
    e.x       = 10'(m_x);
    e.y       = 10'(m_y);
    e.deflect = 10'(m_deflect);
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    bif.frame_tick = 1'b0;
    bif.serve      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_serve();
    @(negedge clk);
    bif.serve = 1'b1;
    @(negedge clk);
    bif.serve = 1'b0;
    model_serve();
  endtask

  task automatic do_frame();
    obs_t e, got;
    int   blen;
    exp_q.push_back(model_frame());
    @(negedge clk);
    bif.frame_tick = 1'b1;
    @(negedge clk);
    bif.frame_tick = 1'b0;
    blen = 0;
    while (bif.busy === 1'b1 && blen < 12) begin
      blen++;
      @(negedge clk);
    end
    got = {bif.ball_x, bif.ball_y, bif.deflect, bif.goal_l, bif.goal_r, 4'(blen)};
    e   = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL frame: got x=%0d y=%0d defl=%h goals=%b busy=%0d, want x=%0d y=%0d defl=%h goals=%b busy=%0d",
               got.x, got.y, got.deflect, got.goals, got.busy_len, e.x, e.y, e.deflect, e.goals, e.busy_len);
    end
    if (e.goals != 2'b00) begin
      @(negedge clk);
      n_cmp++;
      if ({bif.goal_l, bif.goal_r} !== 2'b00) begin
        n_err++;
        $display("FAIL goal_width: got goals=%b one cycle later, want 00", {bif.goal_l, bif.goal_r});
      end
    end
  endtask

  task automatic do_idle_tick();
    int busy_seen = 0;
    @(negedge clk);
    bif.frame_tick = 1'b1;
    @(negedge clk);
    bif.frame_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bif.busy === 1'b1) busy_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (busy_seen != 0 || bif.ball_x !== 10'd316 || bif.ball_y !== 10'd236) begin
      n_err++;
      $display("FAIL idle_tick: got busy_cycles=%0d x=%0d y=%0d, want 0 316 236", busy_seen, bif.ball_x, bif.ball_y);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bif.ball_x, bif.ball_y, bif.deflect, bif.goal_l, bif.goal_r, bif.busy} !==
        {10'd316, 10'd236, 10'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: got x=%0d y=%0d defl=%h gl=%b gr=%b busy=%b, want 316 236 000 0 0 0",
               bif.ball_x, bif.ball_y, bif.deflect, bif.goal_l, bif.goal_r, bif.busy);
    end
  endtask

  task automatic test_first_frame();
    do_reset();
    do_serve();
    do_frame();
    n_cmp++;
    if (bif.ball_x !== 10'd312 || bif.ball_y !== 10'd236) begin
      n_err++;
      $display("FAIL first_frame: got (%0d,%0d), want (312,236)", bif.ball_x, bif.ball_y);
    end
  endtask

  task automatic test_left_hit_down();
    do_reset();
    bif.lpaddle_y = 10'd200;
    bif.rpaddle_y = 10'd0;
    do_serve();
    repeat (73) do_frame();
    n_cmp++;
    if (bif.ball_x !== 10'd24 || bif.deflect !== 10'h008) begin
      n_err++;
      $display("FAIL left_hit_down: got x=%0d defl=%h, want 24 008", bif.ball_x, bif.deflect);
    end
    do_frame();
    n_cmp++;
    if (bif.ball_x !== 10'd28 || bif.ball_y !== 10'd238) begin
      n_err++;
      $display("FAIL after_left_hit: got (%0d,%0d), want (28,238)", bif.ball_x, bif.ball_y);
    end
  endtask

  task automatic test_reset_midframe();
    int busy_seen = 0;
    int goal_seen = 0;
    @(negedge clk);
    bif.frame_tick = 1'b1;
    @(negedge clk);
    bif.frame_tick = 1'b0;
    n_cmp++;
    if (bif.busy !== 1'b1) begin
      n_err++;
      $display("FAIL midframe_busy: got busy=%b, want 1", bif.busy);
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({bif.ball_x, bif.ball_y, bif.deflect, bif.goal_l, bif.goal_r, bif.busy} !==
        {10'd316, 10'd236, 10'd0, 3'b000}) begin
      n_err++;
      $display("FAIL midframe_reset: got x=%0d y=%0d defl=%h gl=%b gr=%b busy=%b, want 316 236 000 0 0 0",
               bif.ball_x, bif.ball_y, bif.deflect, bif.goal_l, bif.goal_r, bif.busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    // serve and tick together: serve wins, the tick is dropped
    bif.serve      = 1'b1;
    bif.frame_tick = 1'b1;
    @(negedge clk);
    bif.serve      = 1'b0;
    bif.frame_tick = 1'b0;
    model_serve();
    for (int i = 0; i < 4; i++) begin
      if (bif.busy === 1'b1) busy_seen++;
      if (bif.goal_l === 1'b1 || bif.goal_r === 1'b1) goal_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (busy_seen != 0 || goal_seen != 0 || bif.ball_x !== 10'd316 || bif.ball_y !== 10'd236) begin
      n_err++;
      $display("FAIL serve_tick_same_cycle: got busy_cycles=%0d goal_cycles=%0d x=%0d y=%0d, want 0 0 316 236",
               busy_seen, goal_seen, bif.ball_x, bif.ball_y);
    end
    do_frame();
    n_cmp++;
    if (bif.ball_x !== 10'd312) begin
      n_err++;
      $display("FAIL serve_after_reset_left: got x=%0d, want 312", bif.ball_x);
    end
  endtask

  task automatic test_left_hit_up_wall();
    do_reset();
    bif.lpaddle_y = 10'd243;
    do_serve();
    repeat (73) do_frame();
    n_cmp++;
    if (bif.ball_x !== 10'd24 || bif.deflect !== 10'h223) begin
      n_err++;
      $display("FAIL left_hit_up: got x=%0d defl=%h, want 24 223", bif.ball_x, bif.deflect);
    end
    repeat (33) do_frame();
    n_cmp++;
    if (bif.ball_y !== 10'd5) begin
      n_err++;
      $display("FAIL near_top: got y=%0d, want 5", bif.ball_y);
    end
    do_frame();
    n_cmp++;
    if (bif.ball_y !== 10'd0) begin
      n_err++;
      $display("FAIL top_clamp: got y=%0d, want 0", bif.ball_y);
    end
    do_frame();
    n_cmp++;
    if (bif.ball_y !== 10'd7) begin
      n_err++;
      $display("FAIL top_bounce: got y=%0d, want 7", bif.ball_y);
    end
  endtask

  task automatic test_goal_and_right();
    do_reset();
    bif.lpaddle_y = 10'd0;
    bif.rpaddle_y = 10'd200;
    do_serve();
    repeat (79) do_frame();
    n_cmp++;
    if (bif.ball_x !== 10'd0 || bif.goal_r !== 1'b0) begin
      n_err++;
      $display("FAIL before_goal: got x=%0d goal_r=%b, want 0 0", bif.ball_x, bif.goal_r);
    end
    do_frame();
    do_idle_tick();
    do_idle_tick();
    // second serve since reset heads right towards the right paddle
    do_serve();
    repeat (73) do_frame();
    n_cmp++;
    if (bif.ball_x !== 10'd608 || bif.deflect !== 10'h008) begin
      n_err++;
      $display("FAIL right_hit: got x=%0d defl=%h, want 608 008", bif.ball_x, bif.deflect);
    end
    do_frame();
    n_cmp++;
    if (bif.ball_x !== 10'd604 || bif.ball_y !== 10'd238) begin
      n_err++;
      $display("FAIL after_right_hit: got (%0d,%0d), want (604,238)", bif.ball_x, bif.ball_y);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    bif.frame_tick = 1'b0;
    bif.serve      = 1'b0;
    bif.lpaddle_y  = 10'd0;
    bif.rpaddle_y  = 10'd0;
    model_reset();
    test_reset();
    test_first_frame();
    test_left_hit_down();
    test_reset_midframe();
    test_left_hit_up_wall();
    test_goal_and_right();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
